// File: rtl/qsys_10g_led_pkg.sv
// ---------------------------------------------------------------------------
// qsys_10g_led_pkg
// Shared definitions for the 10G board LED driver and its per-LED channels.
//   led_mode_e : per-LED behaviour select (off / direct / activity / blink)
//   STRETCH_W  : width of the per-LED activity stretch counter
// ---------------------------------------------------------------------------
package qsys_10g_led_pkg;

  localparam int STRETCH_W = 8;

  typedef enum logic [1:0] {
    LED_MODE_OFF      = 2'b00,
    LED_MODE_DIRECT   = 2'b01,
    LED_MODE_ACTIVITY = 2'b10,
    LED_MODE_BLINK    = 2'b11
  } led_mode_e;

endpackage

// File: rtl/qsys_10g_led_channel.sv
// ---------------------------------------------------------------------------
// qsys_10g_led_channel
// One LED channel: activity stretch counter plus the mode multiplexer that
// decides whether this LED is lit (lit_o = 1) this cycle.
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   tick_i          : shared millisecond-class tick pulse
//   blink_phase_i   : shared blink phase (0 = unlit half)
//   pio_i           : this LED's bit of the PIO pattern
//   pulse_i         : single-cycle activity strobe
//   mode_i          : 2-bit mode select (see led_mode_e)
//   lit_o           : 1 = LED should be lit (before polarity / lamp test)
// ---------------------------------------------------------------------------
module qsys_10g_led_channel
  import qsys_10g_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       blink_phase_i,
  input  logic       pio_i,
  input  logic       pulse_i,
  input  logic [1:0] mode_i,
  output logic       lit_o
);

  logic [STRETCH_W-1:0] stretch_q;
  logic [STRETCH_W-1:0] stretch_d;
  led_mode_e            mode;

  assign mode = led_mode_e'(mode_i);

  // A pulse always reloads, even on a tick, so a retrigger never loses a
  // tick of stretch. Outside activity mode the counter is held at zero so
  // switching back into activity mode starts dark.
  always_comb begin
    stretch_d = stretch_q;
    if (mode != LED_MODE_ACTIVITY) begin
      stretch_d = '0;
    end else if (pulse_i) begin
      stretch_d = STRETCH_W'(STRETCH_TICKS);
    end else if (tick_i && (stretch_q != '0)) begin
      stretch_d = stretch_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end

  always_comb begin
    lit_o = 1'b0;
    case (mode)
      LED_MODE_OFF:      lit_o = 1'b0;
      LED_MODE_DIRECT:   lit_o = pio_i;
      LED_MODE_ACTIVITY: lit_o = (stretch_q != '0);
      LED_MODE_BLINK:    lit_o = pio_i & blink_phase_i;
      default:           lit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/qsys_10g_led_driver.sv
// ---------------------------------------------------------------------------
// qsys_10g_led_driver
// Drives the board LED pins from the LED PIO pattern and MAC activity strobes.
// Holds the tick prescaler, the shared blink generator and the registered
// pin stage (lamp test + pin polarity); per-LED logic lives in channels.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   pio_out    : LED PIO level pattern
//   act_pulse  : per-LED single-cycle activity strobes
//   mode_sel   : per-LED mode, bits [2i+1:2i] for LED i
//   lamp_test  : 1 = force every LED lit
//   tick       : one-cycle pulse every TICK_DIV clocks
//   led_pin    : registered LED pin drive
// ---------------------------------------------------------------------------
module qsys_10g_led_driver
  import qsys_10g_led_pkg::*;
#(
  parameter int NUM_LEDS         = 4,
  parameter int TICK_DIV         = 156250,
  parameter int STRETCH_TICKS    = 50,
  parameter int BLINK_HALF_TICKS = 250,
  parameter int LED_ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEDS-1:0]   pio_out,
  input  logic [NUM_LEDS-1:0]   act_pulse,
  input  logic [2*NUM_LEDS-1:0] mode_sel,
  input  logic                  lamp_test,
  output logic                  tick,
  output logic [NUM_LEDS-1:0]   led_pin
);

  localparam int   PRE_W   = $clog2(TICK_DIV);
  localparam int   BLINK_W = 16;
  localparam logic POL     = (LED_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    pre_q,   pre_d;
  logic                tick_q,  tick_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] pin_q,   pin_d;
  logic [NUM_LEDS-1:0] lit;
  logic                pre_wrap;

  // The tick register fires the cycle after the prescaler sits at its last
  // count, so the first tick appears TICK_DIV clocks after reset release.
  assign pre_wrap = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
    tick_d  = pre_wrap;
    blink_d = blink_q;
    phase_d = phase_q;
    if (tick_q) begin
      if (blink_q == BLINK_W'(BLINK_HALF_TICKS - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    pin_d = (lit | {NUM_LEDS{lamp_test}}) ^ {NUM_LEDS{POL}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pin_q   <= {NUM_LEDS{POL}};
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pin_q   <= pin_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    qsys_10g_led_channel #(
      .STRETCH_TICKS (STRETCH_TICKS)
    ) u_chan (
      .clk_i         (clk),
      .rst_i         (reset),
      .tick_i        (tick_q),
      .blink_phase_i (phase_q),
      .pio_i         (pio_out[i]),
      .pulse_i       (act_pulse[i]),
      .mode_i        (mode_sel[2*i +: 2]),
      .lit_o         (lit[i])
    );
  end

  assign tick    = tick_q;
  assign led_pin = pin_q;

endmodule

// File: tb/tb_qsys_10g_led_driver.sv
// ---------------------------------------------------------------------------
// tb_qsys_10g_led_driver
// Self-checking bench for qsys_10g_led_driver with a small prescaler so
// ticks, stretching and blinking are visible within a few dozen clocks.
// A cycle model predicts {tick, led_pin} for each clock edge; predictions
// are queued when inputs are driven and popped once the DUT has updated.
// ---------------------------------------------------------------------------
module tb_qsys_10g_led_driver;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int BH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pioOut;
  logic [3:0] actPulse;
  logic [7:0] modeSel;
  logic       lampTest;
  logic       tickO;
  logic [3:0] ledPin;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] sb[$];
  logic [4:0] exp;

  int   mPre;
  int   mBcnt;
  logic mTick;
  logic mPhase;
  int   mStr[4];

  qsys_10g_led_driver #(
    .NUM_LEDS         (4),
    .TICK_DIV         (TD),
    .STRETCH_TICKS    (ST),
    .BLINK_HALF_TICKS (BH),
    .LED_ACTIVE_LOW   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pio_out   (pioOut),
    .act_pulse (actPulse),
    .mode_sel  (modeSel),
    .lamp_test (lampTest),
    .tick      (tickO),
    .led_pin   (ledPin)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mPre   = 0;
    mBcnt  = 0;
    mTick  = 1'b0;
    mPhase = 1'b0;
    for (int i = 0; i < 4; i++) mStr[i] = 0;
    sb.delete();
  endtask

  // Predict the outputs after the next edge, queue them, advance one clock
  // and update the model; returns #1 after the edge with inputs unchanged.
  task automatic stepClk();
    logic [3:0] lit;
    logic       newTick;
    for (int i = 0; i < 4; i++) begin
      case (modeSel[2*i +: 2])
        2'b00:   lit[i] = 1'b0;
        2'b01:   lit[i] = pioOut[i];
        2'b10:   lit[i] = (mStr[i] != 0);
        default: lit[i] = pioOut[i] & mPhase;
      endcase
    end
    newTick = (mPre == TD - 1);
    sb.push_back({newTick, (lit | {4{lampTest}}) ^ 4'hF});
    @(posedge clk);
    if (mTick) begin
      if (mBcnt == BH - 1) begin
        mBcnt  = 0;
        mPhase = ~mPhase;
      end else begin
        mBcnt = mBcnt + 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (modeSel[2*i +: 2] != 2'b10) mStr[i] = 0;
      else if (actPulse[i])           mStr[i] = ST;
      else if (mTick && mStr[i] != 0) mStr[i] = mStr[i] - 1;
    end
    mTick = newTick;
    mPre  = (mPre == TD - 1) ? 0 : mPre + 1;
    #1;
  endtask

  task automatic test_reset();
    int firstTick;
    firstTick = 0;
    reset    = 1'b1;
    pioOut   = 4'hF;
    actPulse = 4'h0;
    modeSel  = 8'h55;
    lampTest = 1'b0;
    modelReset();
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (ledPin !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL reset_pins: got %h want %h", ledPin, 4'hF);
    end
    vectors++;
    if (tickO !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tick: got %b want 0", tickO);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset_seq: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
      if (tickO === 1'b1 && firstTick == 0) firstTick = k;
      if (k == 1) begin
        vectors++;
        if (ledPin !== 4'h0) begin
          miscompares++;
          $display("[TB] FAIL reset_first_pin: got %h want %h", ledPin, 4'h0);
        end
      end
    end
    vectors++;
    if (firstTick != TD) begin
      miscompares++;
      $display("[TB] FAIL first_tick: got clk %0d want clk %0d", firstTick, TD);
    end
  endtask

  task automatic test_direct();
    modeSel = 8'h55;
    pioOut  = 4'h0;
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL direct_off: got %b/%h want %b/%h", tickO, ledPin, exp[4], 4'hF);
    end
    pioOut = 4'hA;
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin !== 4'h5) begin
      miscompares++;
      $display("[TB] FAIL direct_on: got %b/%h want %b/%h", tickO, ledPin, exp[4], 4'h5);
    end
  endtask

  task automatic test_activity();
    int guard;
    int litCount;
    modeSel = 8'hAA;
    pioOut  = 4'h0;
    repeat (2) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL act_idle: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
    actPulse = 4'h1;
    stepClk();
    actPulse = 4'h0;
    exp = sb.pop_front();
    for (int k = 0; k < 20; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL act_stretch: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
    // Line the next pulse up with a tick to exercise the retrigger rule.
    guard = 0;
    while (!mTick && guard < 8) begin
      stepClk();
      exp = sb.pop_front();
      guard++;
    end
    vectors++;
    if (!mTick) begin
      miscompares++;
      $display("[TB] FAIL act_tick_align: got no tick want tick within 8 clk");
    end
    actPulse = 4'h1;
    stepClk();
    actPulse = 4'h0;
    exp = sb.pop_front();
    litCount = 0;
    for (int k = 0; k < 30; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL act_retrigger: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
      if (ledPin[0] === 1'b0) litCount++;
    end
    vectors++;
    if (litCount != ST * TD) begin
      miscompares++;
      $display("[TB] FAIL act_coincident_len: got %0d lit clk want %0d", litCount, ST * TD);
    end
  endtask

  task automatic test_blink();
    modeSel = 8'hFF;
    pioOut  = 4'h3;
    for (int k = 0; k < 24; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp || ledPin[3:2] !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL blink: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
    pioOut = 4'h0;
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL blink_off: got %b/%h want %b/%h", tickO, ledPin, exp[4], 4'hF);
    end
  endtask

  task automatic test_lamp();
    modeSel  = 8'h00;
    lampTest = 1'b1;
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL lamp_on: got %b/%h want %b/%h", tickO, ledPin, exp[4], 4'h0);
    end
    lampTest = 1'b0;
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL lamp_off: got %b/%h want %b/%h", tickO, ledPin, exp[4], 4'hF);
    end
  endtask

  task automatic test_mode_change();
    modeSel  = 8'hAA;
    actPulse = 4'h1;
    stepClk();
    actPulse = 4'h0;
    exp = sb.pop_front();
    stepClk();
    exp = sb.pop_front();
    vectors++;
    if ({tickO, ledPin} !== exp || ledPin[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mode_pre: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
    end
    modeSel = 8'h00;
    stepClk();
    exp = sb.pop_front();
    modeSel = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp || ledPin[0] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL mode_cleared: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
    modeSel = 8'hFF;
    pioOut  = 4'h3;
    for (int k = 0; k < 14; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL mode_blink: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
    // Reset lands between edges; pins must go dark without waiting for a clock.
    reset = 1'b1;
    modelReset();
    #1;
    vectors++;
    if (ledPin !== 4'hF || tickO !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b/%h want 0/%h", tickO, ledPin, 4'hF);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stepClk();
      exp = sb.pop_front();
      vectors++;
      if ({tickO, ledPin} !== exp) begin
        miscompares++;
        $display("[TB] FAIL post_reset: got %b/%h want %b/%h", tickO, ledPin, exp[4], exp[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_activity();
    test_blink();
    test_lamp();
    test_mode_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
